// File: rtl/cache_data_array_ctrl.sv
// Request-side controller for the cache data SRAM: clears every word after reset,
// then turns a valid/ready request stream into SRAM cycles and returns read data.
module cache_data_array_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      init_done_q  <= init_done_d;
    end
  end

  // Last issued address/data, replayed on idle cycles so the SRAM pins stay quiet.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    init_done_d  = init_done_q;
    addr_d       = addr_q;
    din_d        = din_q;
    req_ready    = 1'b0;
    sram_csb     = 1'b1;
    sram_web     = 1'b1;
    sram_wmask   = '0;
    sram_addr    = addr_q;
    sram_din     = din_q;

    case (state_q)
      INIT: begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_wmask = '1;
        sram_addr  = cnt_q;
        sram_din   = INIT_VALUE;
        addr_d     = cnt_q;
        din_d      = INIT_VALUE;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // A stalled response blocks new accesses so sram_dout cannot change under it.
        req_ready = !resp_valid_q || resp_ready;
        if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;
        if (req_valid && req_ready) begin
          sram_csb   = 1'b0;
          sram_web   = !req_we;
          sram_addr  = req_addr;
          sram_wmask = req_wmask;
          sram_din   = req_wdata;
          addr_d     = req_addr;
          din_d      = req_wdata;
          if (!req_we) resp_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    // Keep the macro deselected during the reset cycle itself.
    if (rst) begin
      req_ready = 1'b0;
      sram_csb  = 1'b1;
      sram_web  = 1'b1;
    end
  end

  assign resp_valid = resp_valid_q;
  assign init_done  = init_done_q;
  assign resp_rdata = sram_dout;

endmodule

// File: tb/tb_cache_data_array_ctrl.sv
// Bench for cache_data_array_ctrl: behavioural SRAM macro plus a word-array reference
// model of memory contents and the pending read response.
module tb_cache_data_array_ctrl;
  localparam int AW = 5;
  localparam int DW = 256;
  localparam int NW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [NW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          sram_csb, sram_web;
  logic [NW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  cache_data_array_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM macro: inputs registered when csb=0, write lands at the following edge,
  // dout follows the registered address.
  logic [DW-1:0] smem [DEPTH];
  logic [AW-1:0] s_addr_r;
  logic          s_wp = 1'b0;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd;
  logic [NW-1:0] s_wm;
  always @(posedge clk) begin : sram_model
    logic [DW-1:0] w;
    if (s_wp) begin
      w = smem[s_wa];
      for (int b = 0; b < NW; b++) if (s_wm[b]) w[b*8 +: 8] = s_wd[b*8 +: 8];
      smem[s_wa] <= w;
    end
    s_wp <= !sram_csb && !sram_web;
    if (!sram_csb) begin
      s_addr_r <= sram_addr;
      s_wa     <= sram_addr;
      s_wd     <= sram_din;
      s_wm     <= sram_wmask;
    end
  end
  assign sram_dout = smem[s_addr_r];

  // Reference model
  logic [DW-1:0] ref_mem [DEPTH];
  logic          m_run = 1'b0;
  int            m_cnt = 0;
  logic          m_rv = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_din = '0;
  int            n_resp = 0;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input int a, input logic [NW-1:0] m,
                       input logic [DW-1:0] d, input logic rr);
    req_valid  = v;
    req_we     = we;
    req_addr   = AW'(a);
    req_wmask  = m;
    req_wdata  = d;
    resp_ready = rr;
  endtask

  // One clock: check pins against the model just before the edge, then advance the model.
  task automatic tick();
    logic exp_rdy, acc;
    #1;
    exp_rdy = !rst && m_run && (!m_rv || resp_ready);
    acc     = req_valid && exp_rdy;
    chk1("req_ready", req_ready, exp_rdy);
    chk1("resp_valid", resp_valid, m_rv);
    chk1("init_done", init_done, m_run);
    if (m_rv) chkw("resp_rdata", resp_rdata, m_rdata);
    if (rst) begin
      chk1("rst_csb", sram_csb, 1'b1);
      chk1("rst_web", sram_web, 1'b1);
    end else if (!m_run) begin
      chk1("init_csb", sram_csb, 1'b0);
      chk1("init_web", sram_web, 1'b0);
      chkw("init_wmask", DW'(sram_wmask), DW'({NW{1'b1}}));
      chkw("init_addr", DW'(sram_addr), DW'(m_cnt));
      chkw("init_din", sram_din, '0);
    end else if (acc) begin
      chk1("acc_csb", sram_csb, 1'b0);
      chk1("acc_web", sram_web, !req_we);
      chkw("acc_addr", DW'(sram_addr), DW'(req_addr));
      chkw("acc_wmask", DW'(sram_wmask), DW'(req_wmask));
      chkw("acc_din", sram_din, req_wdata);
    end else begin
      chk1("idle_csb", sram_csb, 1'b1);
      chk1("idle_web", sram_web, 1'b1);
      chkw("idle_wmask", DW'(sram_wmask), '0);
      chkw("idle_addr", DW'(sram_addr), DW'(m_last_addr));
      chkw("idle_din", sram_din, m_last_din);
    end
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_rv  = 1'b0;
    end else if (!m_run) begin
      ref_mem[m_cnt] = '0;
      m_last_addr = AW'(m_cnt);
      m_last_din  = '0;
      if (m_cnt == DEPTH - 1) m_run = 1'b1;
      m_cnt++;
    end else begin
      if (m_rv && resp_ready) begin
        m_rv = 1'b0;
        n_resp++;
      end
      if (acc) begin
        m_last_addr = req_addr;
        m_last_din  = req_wdata;
        if (req_we) begin
          for (int b = 0; b < NW; b++)
            if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          m_rv    = 1'b1;
          m_rdata = ref_mem[req_addr];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n0;
    logic [DW-1:0] rnd;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    @(negedge clk);
    tick();
    tick();
    chk1("reset_resp_valid", resp_valid, 1'b0);
    chk1("reset_init_done", init_done, 1'b0);

    // Clear phase: the model requires init_done low for 32 cycles, then high.
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    chk1("init_done_after_32", init_done, 1'b1);

    // Streaming reads of every address; all must come back as the cleared value.
    n0 = n_resp;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b0, a, '0, '0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    tick();
    chkw("stream_resp_count", DW'(n_resp - n0), DW'(DEPTH));

    // Full write then read-after-write of the same word.
    drive(1'b1, 1'b1, 5, '1, {32{8'hA5}}, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    #1;
    chk1("raw_resp_valid", resp_valid, 1'b1);
    chkw("raw_rdata", resp_rdata, {32{8'hA5}});
    tick();

    // Single-byte masked write over the A5 line.
    drive(1'b1, 1'b1, 5, 32'h0000_0001, {{31{8'h00}}, 8'h3C}, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    #1;
    chkw("masked_rdata", resp_rdata, {{31{8'hA5}}, 8'h3C});
    tick();

    // A zero-mask write must leave the line untouched.
    drive(1'b1, 1'b1, 5, '0, '1, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    #1;
    chkw("zero_mask_rdata", resp_rdata, {{31{8'hA5}}, 8'h3C});
    tick();

    // Back-pressure: read 7 stalls for 4 cycles while a read of 8 waits.
    rnd = {8{$urandom}};
    drive(1'b1, 1'b1, 7, '1, rnd, 1'b1);
    tick();
    drive(1'b1, 1'b1, 8, '1, ~rnd, 1'b1);
    tick();
    drive(1'b1, 1'b0, 7, '0, '0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chkw("stall_rdata_stable", resp_rdata, rnd);
    end
    resp_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    #1;
    chkw("after_stall_rdata", resp_rdata, ~rnd);
    tick();

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
            ($urandom_range(0, 7) == 0) ? '0 : NW'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) != 0);
      tick();
    end

    // Reset while a read response is pending, at RUN cycle 10.
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), NW'($urandom),
            {8{$urandom}}, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 3, '0, '0, 1'b0);
    tick();
    chk1("pending_before_rst", resp_valid, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4, '0, '0, 1'b0);
    tick();
    chk1("rst_drops_resp", resp_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    chk1("reinit_done", init_done, 1'b1);
    drive(1'b1, 1'b0, 3, '0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    #1;
    chkw("reinit_read_zero", resp_rdata, '0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_data_array_ctrl.md
Name: cache_data_array_ctrl

Overview:
- Request-side controller that initiates all traffic into the cache data SRAM macro. The macro is 32 words x 256 bits, with a 32-bit byte write mask, active-low csb/web, registered inputs and dout driven from the registered address.
- Clears every word after reset.
- Converts a valid/ready request stream from the cache FSM into SRAM cycles.
- Returns read data on a valid/ready response channel, and holds the SRAM stable while the response is back-pressured.

Parameters:
- ADDR_WIDTH, 5, SRAM address bits; depth is 1<<ADDR_WIDTH.
- DATA_WIDTH, 256, line width in bits.
- NUM_WMASKS, 32, byte-enable count; equals DATA_WIDTH/8.
- INIT_VALUE, 0, value written to every word during the post-reset clear (DATA_WIDTH bits).

Ports:
- clk  in  1  clock; the SRAM clk0 uses the same clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wmask  in  NUM_WMASKS  byte enables; used only for writes.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_WIDTH  read data; equals sram_dout.
- init_done  out  1  post-reset clear complete.
- sram_csb  out  1  to csb0, active low.
- sram_web  out  1  to web0, active low.
- sram_wmask  out  NUM_WMASKS  to wmask0.
- sram_addr  out  ADDR_WIDTH  to addr0.
- sram_din  out  DATA_WIDTH  to din0.
- sram_dout  in  DATA_WIDTH  from dout0.

Behaviour:
- SRAM timing (fixed):
  - Inputs are sampled at the clk edge when csb=0.
  - The write lands in mem at the following edge.
  - dout reflects the sampled address after the sampling edge.
  - With csb=1 the sampled registers hold, so dout stays stable.
- FSM states: INIT, RUN.
- Reset:
  - state=INIT, init counter=0, resp_valid=0, init_done=0, req_ready=0.
  - sram_csb=1, sram_web=1 during the reset cycle.
  - Reset mid-operation:
    - A pending response is dropped.
    - The clear restarts at address 0.
    - SRAM contents are not otherwise guaranteed.
- INIT:
  - Drives each cycle: csb=0, web=0, wmask=all ones, addr=counter, din=INIT_VALUE.
  - Counter increments every cycle.
  - After address (1<<ADDR_WIDTH)-1 is issued, move to RUN; init_done rises in the first RUN cycle and stays 1 until reset.
  - Clear duration is exactly 32 cycles for the default parameters.
  - req_ready=0 throughout.
- RUN handshake:
  - req_ready = !resp_valid || resp_ready.
  - A request is accepted when req_valid && req_ready.
  - In the accept cycle the SRAM pins are driven combinationally from the request: csb=0, web=!req_we, addr, wmask, din.
- RUN non-accept cycles:
  - csb=1.
  - web=1, wmask=0, addr/din hold the last values.
- Reads:
  - resp_valid rises the cycle after acceptance; resp_rdata=sram_dout (combinational passthrough).
  - While resp_valid && !resp_ready, no SRAM access is made (csb=1), so data stays stable.
  - resp_valid clears after a handshake unless a new read is accepted in the same cycle, in which case it stays 1 for the new data.
  - Throughput: one read per cycle with resp_ready held high.
- Writes:
  - No response is generated.
  - resp_valid is unaffected, except that a write accepted during a response handshake still clears resp_valid.
  - Back-to-back writes run at one per cycle.
- Read after write, same address, in the next cycle: returns the new data (SRAM ordering guarantees this). No forwarding logic.
- A write with wmask=0 is issued as a normal SRAM cycle and changes nothing.
- req_* inputs are ignored when req_ready=0.

Test Plan:
- Reset release, then read all 32 addresses after init_done=1. Required: init_done rises exactly 32 cycles after rst drops; every read returns 0.
- Write addr 5, data 0xA5 repeated, mask all ones; next cycle read addr 5. Required: resp_valid one cycle after the read is accepted; rdata=0xA5 repeated.
- Write addr 5, wmask=0x0000_0001, din byte0=0x3C, over the prior 0xA5 line; then read addr 5. Required: byte0=0x3C, other 31 bytes=0xA5.
- Read addr 7 with resp_ready=0 for 4 cycles while req_valid is held with a read of addr 8. Required: req_ready=0, sram_csb=1 and rdata stable for all 4 cycles; after resp_ready, addr 8 is accepted the same cycle and its data appears next cycle.
- Streaming reads of addr 0..31 with resp_ready=1. Required: 32 responses on 32 consecutive cycles, in order.
- Assert rst during a pending read response at cycle 10 of RUN. Required: resp_valid=0 the next cycle; the clear reruns from address 0; init_done=0 for 32 cycles.
